// File: rtl/tx_pcs_encoder.sv
// tx_pcs_encoder: pairs XGMII words into 64b/66b blocks with TX framing check; define TX_PCS_ENCODER_ERR_CNT_EN to add o_err_cnt
module tx_pcs_encoder #(
  parameter int XGMII_DATA_WIDTH = 32,
  parameter int XGMII_CTRL_WIDTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic [XGMII_DATA_WIDTH-1:0] i_xgmii_txd,
  input  logic [XGMII_CTRL_WIDTH-1:0] i_xgmii_ctrl,
  input  logic                        i_xgmii_valid,
  output logic                        o_xgmii_pause,
  input  logic                        i_tx_pause,
  output logic [XGMII_DATA_WIDTH-1:0] o_tx_data,
  output logic [1:0]                  o_tx_hdr,
  output logic                        o_tx_hdr_valid,
  output logic                        o_tx_valid
`ifdef TX_PCS_ENCODER_ERR_CNT_EN
  ,
  output logic [15:0]                 o_err_cnt
`endif
);
  typedef enum logic {TX_C, TX_D} state_t;
  typedef enum logic [2:0] {CL_D, CL_C, CL_S, CL_T, CL_E} cls_t;
  localparam logic [63:0] IDLE8   = {8{8'h07}};
  localparam logic [63:0] E_BLK   = {{8{7'h1E}}, 8'h1E};
  localparam logic [63:0] T_TYPES = {8'hFF, 8'hE1, 8'hD2, 8'hCC, 8'hB4, 8'hAA, 8'h99, 8'h87};
  state_t                        state_q, state_d, nstate;
  cls_t                          cls;
  logic                          phase_q, phase_d, hi, ok;
  logic [XGMII_DATA_WIDTH-1:0]   lo_data_q, lo_data_d, upper_q, upper_d, tx_data_q, tx_data_d;
  logic [XGMII_CTRL_WIDTH-1:0]   lo_ctrl_q, lo_ctrl_d;
  logic [1:0]                    tx_hdr_q, tx_hdr_d, hdr;
  logic                          tx_hdr_valid_q, tx_hdr_valid_d, tx_valid_q, tx_valid_d;
  logic [63:0]                   blk, enc, payload;
  logic [7:0]                    c8;
  assign o_xgmii_pause  = i_tx_pause;
  assign o_tx_data      = tx_data_q;
  assign o_tx_hdr       = tx_hdr_q;
  assign o_tx_hdr_valid = tx_hdr_valid_q;
  assign o_tx_valid     = tx_valid_q;
  // classify and encode the block formed by the held lower word and the current word
  always_comb begin
    blk = {i_xgmii_txd, lo_data_q};
    c8  = {i_xgmii_ctrl, lo_ctrl_q};
    cls = CL_E;
    enc = E_BLK;
    if (c8 == 8'h00) begin
      cls = CL_D;
      enc = blk;
    end else if (c8 == 8'hFF && blk == IDLE8) begin
      cls = CL_C;
      enc = 64'h1E;
    end else if (c8 == 8'h01 && blk[7:0] == 8'hFB) begin
      cls = CL_S;
      enc = {blk[63:8], 8'h78};
    end else if (c8 == 8'h1F && blk[39:0] == 40'hFB07070707) begin
      cls = CL_S;
      enc = {blk[63:40], 32'h0, 8'h33};
    end else begin
      for (int k = 0; k < 8; k++)
        if (c8 == 8'(8'hFF << k) && blk[8*k+:8] == 8'hFD && (blk >> (8*k+8)) == (IDLE8 >> (8*k+8))) begin
          cls = CL_T;
          enc = ((blk & ((64'h1 << (8*k)) - 64'h1)) << 8) | {56'h0, T_TYPES[8*k+:8]};
        end
    end
  end
  // framing check, output beat selection and next-state values
  always_comb begin
    hi             = phase_q & i_xgmii_valid;
    ok             = state_q == TX_C ? (cls == CL_C || cls == CL_S) : (cls == CL_D || cls == CL_T);
    nstate         = (state_q == TX_C && cls == CL_S) || (state_q == TX_D && cls == CL_D) ? TX_D : TX_C;
    payload        = ok ? enc : E_BLK;
    hdr            = ok && cls == CL_D ? 2'b01 : 2'b10;
    phase_d        = phase_q ^ i_xgmii_valid;
    lo_data_d      = i_xgmii_valid && !phase_q ? i_xgmii_txd : lo_data_q;
    lo_ctrl_d      = i_xgmii_valid && !phase_q ? i_xgmii_ctrl : lo_ctrl_q;
    state_d        = hi ? nstate : state_q;
    tx_data_d      = !i_xgmii_valid ? tx_data_q : phase_q ? payload[31:0] : upper_q;
    tx_hdr_d       = hi ? hdr : tx_hdr_q;
    tx_hdr_valid_d = i_xgmii_valid ? phase_q : tx_hdr_valid_q;
    upper_d        = hi ? payload[63:32] : upper_q;
    tx_valid_d     = i_xgmii_valid;
  end
  // pairing phase, framing state and registered outputs
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      phase_q        <= 1'b0;
      state_q        <= TX_C;
      lo_data_q      <= '0;
      lo_ctrl_q      <= '0;
      upper_q        <= '0;
      tx_data_q      <= '0;
      tx_hdr_q       <= 2'b10;
      tx_hdr_valid_q <= 1'b0;
      tx_valid_q     <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      state_q        <= state_d;
      lo_data_q      <= lo_data_d;
      lo_ctrl_q      <= lo_ctrl_d;
      upper_q        <= upper_d;
      tx_data_q      <= tx_data_d;
      tx_hdr_q       <= tx_hdr_d;
      tx_hdr_valid_q <= tx_hdr_valid_d;
      tx_valid_q     <= tx_valid_d;
    end
`ifdef TX_PCS_ENCODER_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  assign o_err_cnt = err_cnt_q;
  // saturating count of substituted error blocks
  always_comb err_cnt_d = hi && !ok && err_cnt_q != 16'hFFFF ? err_cnt_q + 16'd1 : err_cnt_q;
  // error counter register
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) err_cnt_q <= '0;
    else err_cnt_q <= err_cnt_d;
`endif
endmodule

// File: tb/tb_tx_pcs_encoder.sv
// tb_tx_pcs_encoder: randomized scoreboard bench for tx_pcs_encoder
module tb_tx_pcs_encoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n, vld, pause_i, pause_o, hv, tv;
  logic [31:0] txd, tx_data;
  logic [3:0]  ctrl;
  logic [1:0]  tx_hdr;
`ifdef TX_PCS_ENCODER_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif
  tx_pcs_encoder dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_xgmii_txd(txd), .i_xgmii_ctrl(ctrl),
    .i_xgmii_valid(vld), .o_xgmii_pause(pause_o), .i_tx_pause(pause_i),
    .o_tx_data(tx_data), .o_tx_hdr(tx_hdr), .o_tx_hdr_valid(hv), .o_tx_valid(tv)
`ifdef TX_PCS_ENCODER_ERR_CNT_EN
    , .o_err_cnt(err_cnt)
`endif
  );
  typedef struct packed {logic [31:0] d; logic [1:0] h; logic hv; logic [15:0] ec;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;
  localparam logic [63:0] IDLE = 64'h0707070707070707;
  logic [7:0] t_types [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
  bit          m_ph, m_in_data;
  logic [31:0] m_lo_w, m_upper;
  logic [3:0]  m_lo_c;
  logic [1:0]  m_hdr;
  int unsigned m_ec;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit run07(logic [63:0] blk, int from, int to);
    for (int i = from; i <= to; i++) if (blk[8*i+:8] != 8'h07) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_in_data = 0; m_lo_w = 0; m_lo_c = 0; m_upper = 0; m_hdr = 2'b10; m_ec = 0;
  endtask

  task automatic encode(input logic [63:0] blk, input logic [7:0] c8, output logic [63:0] pl, output logic [1:0] hdr, output bit ill);
    logic [7:0] b[8];
    logic [7:0] p[8];
    int kind, tk;
    kind = 4; tk = 0;
    for (int i = 0; i < 8; i++) begin b[i] = blk[8*i+:8]; p[i] = 8'h00; end
    if (c8 == 8'h00) kind = 0;
    else if (c8 == 8'hFF && run07(blk, 0, 7)) kind = 1;
    else if (c8 == 8'h01 && b[0] == 8'hFB) kind = 2;
    else if (c8 == 8'h1F && run07(blk, 0, 3) && b[4] == 8'hFB) kind = 5;
    else for (int k = 0; k < 8; k++) begin
      logic [7:0] m;
      m = 8'hFF << k;
      if (c8 == m && b[k] == 8'hFD && run07(blk, k + 1, 7)) begin kind = 3; tk = k; end
    end
    ill = m_in_data ? !(kind == 0 || kind == 3) : !(kind == 1 || kind == 2 || kind == 5);
    m_in_data = !ill && (kind == 0 || kind == 2 || kind == 5);
    hdr = (!ill && kind == 0) ? 2'b01 : 2'b10;
    if (ill) begin
      pl = 64'h1E;
      for (int i = 0; i < 8; i++) pl = pl | (64'h1E << (8 + 7 * i));
    end else begin
      case (kind)
        0: p = b;
        1: p[0] = 8'h1E;
        2: begin p[0] = 8'h78; for (int i = 1; i < 8; i++) p[i] = b[i]; end
        5: begin p[0] = 8'h33; for (int i = 5; i < 8; i++) p[i] = b[i]; end
        default: begin p[0] = t_types[tk]; for (int i = 0; i < tk; i++) p[i+1] = b[i]; end
      endcase
      for (int i = 0; i < 8; i++) pl[8*i+:8] = p[i];
    end
  endtask

  task automatic drive(bit v, logic [31:0] w, logic [3:0] c);
    @(posedge clk);
    #1;
    vld = v; txd = w; ctrl = c; pause_i = 1'($urandom_range(0, 1));
  endtask

  task automatic send_word(logic [31:0] w, logic [3:0] c, int stalls);
    logic [63:0] pl;
    logic [1:0]  hdr;
    bit          ill;
    exp_t        x;
    repeat (stalls) drive(0, $urandom, 4'($urandom));
    drive(1, w, c);
    if (!m_ph) begin
      x.d = m_upper; x.h = m_hdr; x.hv = 1'b0; x.ec = 16'(m_ec);
      m_lo_w = w; m_lo_c = c; m_ph = 1;
    end else begin
      encode({w, m_lo_w}, {c, m_lo_c}, pl, hdr, ill);
      if (ill && m_ec < 65535) m_ec++;
      x.d = pl[31:0]; x.h = hdr; x.hv = 1'b1; x.ec = 16'(m_ec);
      m_upper = pl[63:32]; m_hdr = hdr; m_ph = 0;
    end
    q.push_back(x);
  endtask

  task automatic send_blk(logic [63:0] blk, logic [7:0] c8, int mid_stall);
    send_word(blk[31:0], c8[3:0], 0);
    send_word(blk[63:32], c8[7:4], mid_stall);
  endtask

  task automatic rand_blk();
    logic [63:0] blk;
    logic [7:0]  c8;
    int          kind, k;
    blk = {$urandom, $urandom};
    kind = $urandom_range(0, 10);
    k = $urandom_range(0, 7);
    case (kind)
      0, 1: begin blk = IDLE; c8 = 8'hFF; end
      2: begin blk[7:0] = 8'hFB; c8 = 8'h01; end
      3: begin blk[39:0] = 40'hFB07070707; c8 = 8'h1F; end
      4, 5, 6: c8 = 8'h00;
      7, 8: begin
        for (int i = 0; i < 8; i++) if (i == k) blk[8*i+:8] = 8'hFD; else if (i > k) blk[8*i+:8] = 8'h07;
        c8 = 8'hFF << k;
      end
      9: c8 = 8'($urandom);
      default: begin blk = IDLE; blk[8*k+:8] = 8'hFE; c8 = 8'hFF; end
    endcase
    send_blk(blk, c8, $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_data"}, tx_data, 0);
    chk({tag, "_hdr"}, tx_hdr, 2'b10);
    chk({tag, "_hdr_valid"}, hv, 0);
    chk({tag, "_valid"}, tv, 0);
`ifdef TX_PCS_ENCODER_ERR_CNT_EN
    chk({tag, "_err_cnt"}, err_cnt, 0);
`endif
  endtask

  always @(negedge clk) if (rst_n) begin
    chk("pause", pause_o, pause_i);
    if (tv) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat: got data %h expected no beat", tx_data);
      end else begin
        e = q.pop_front();
        chk("data", tx_data, e.d);
        chk("hdr", tx_hdr, e.h);
        chk("hdr_valid", hv, e.hv);
`ifdef TX_PCS_ENCODER_ERR_CNT_EN
        chk("err_cnt", err_cnt, e.ec);
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 0; vld = 0; txd = 0; ctrl = 0; pause_i = 0;
    model_reset();
    #12;
    reset_checks("rst");
    @(posedge clk);
    #1 rst_n = 1;
    send_blk(IDLE, 8'hFF, 0);
    send_blk(IDLE, 8'hFF, 0);
    send_blk(64'hD5555555_555555FB, 8'h01, 0);
    send_blk(64'h07060504_03020100, 8'h00, 0);
    send_blk(64'h07070707_FDCCBBAA, 8'hF8, 0);
    send_blk(64'h555555FB_07070707, 8'h1F, 0);
    send_blk(64'h11223344_55667788, 8'h00, 0);
    send_blk(64'h07070707_070707FD, 8'hFF, 0);
    send_blk(64'h0BADF00D_DEADBEEF, 8'h00, 0);
    send_blk(64'hD5555555_555555FB, 8'h01, 0);
    send_blk(64'h07060504_03020100, 8'h00, 3);
    send_blk(64'h07070707_07FDBBAA, 8'hFC, 0);
    send_word(32'h07070707, 4'hF, 0);
    repeat (3) drive(0, $urandom, 4'($urandom));
    @(posedge clk);
    #1 rst_n = 0;
    #2;
    reset_checks("midrst");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    send_blk(IDLE, 8'hFF, 0);
    send_blk(64'hD5555555_555555FB, 8'h01, 0);
    send_blk(64'hCAFEF00D_12345678, 8'h00, 2);
    repeat (400) rand_blk();
    drive(0, 0, 0);
    n = 0;
    while (q.size() != 0 && n < 20) begin @(posedge clk); n++; end
    #6;
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: got %0d pending beats expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
